// File: rtl/lane_arbiter.sv
// Two-lane occupancy arbiter: per-lane event FIFOs, round-robin grant, shared occupancy count.
// Define OCC_SAT_EN for a saturating count; by default the count wraps at 0 and MAX_COUNT.
module lane_arbiter #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned COUNT_W    = 4,
  parameter int unsigned MAX_COUNT  = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               lane0_inc,
  input  logic               lane0_dec,
  input  logic               lane1_inc,
  input  logic               lane1_dec,
  output logic [COUNT_W-1:0] count,
  output logic               full,
  output logic               empty,
  output logic               busy,
  output logic               drop,
  output logic               ovf,
  output logic               unf
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam logic [COUNT_W-1:0] MaxCnt   = COUNT_W'(MAX_COUNT);
  localparam logic [PtrW:0]      DepthOcc = (PtrW + 1)'(FIFO_DEPTH);
  localparam logic [PtrW-1:0]    PtrOne   = PtrW'(1);
  localparam logic [PtrW:0]      OccOne   = (PtrW + 1)'(1);
  localparam logic [COUNT_W-1:0] CntOne   = COUNT_W'(1);

  typedef enum logic {StLast0, StLast1} arb_state_e;

  arb_state_e state_q, state_d;

  logic [FIFO_DEPTH-1:0] mem_q    [2];
  logic [PtrW-1:0]       wr_ptr_q [2];
  logic [PtrW-1:0]       rd_ptr_q [2];
  logic [PtrW:0]         occ_q    [2];

  logic [1:0] push_req, push_val, push_ok, pop, not_empty, fifo_full, lost;
  logic       pop_val;

  logic [COUNT_W-1:0] count_q, count_d;
  logic               drop_q, ovf_q, ovf_d, unf_q, unf_d;

  // Simultaneous inc and dec on one lane cancel and never reach the FIFO.
  assign push_req = {lane1_inc ^ lane1_dec, lane0_inc ^ lane0_dec};
  assign push_val = {lane1_inc, lane0_inc};

  always_comb begin
    not_empty = '0;
    fifo_full = '0;
    push_ok   = '0;
    lost      = '0;
    for (int l = 0; l < 2; l++) begin
      not_empty[l] = (occ_q[l] != '0);
      fifo_full[l] = (occ_q[l] == DepthOcc);
      // A full FIFO still accepts a push when it is popped on the same edge.
      push_ok[l]   = push_req[l] && (!fifo_full[l] || pop[l]);
      lost[l]      = push_req[l] && fifo_full[l] && !pop[l];
    end
  end

  // Round-robin grant; on a tie the lane not served last wins.
  always_comb begin
    state_d = state_q;
    pop     = '0;
    if (&not_empty) begin
      if (state_q == StLast1) begin
        pop     = 2'b01;
        state_d = StLast0;
      end else begin
        pop     = 2'b10;
        state_d = StLast1;
      end
    end else if (not_empty[0]) begin
      pop     = 2'b01;
      state_d = StLast0;
    end else if (not_empty[1]) begin
      pop     = 2'b10;
      state_d = StLast1;
    end
  end

  assign pop_val = pop[1] ? mem_q[1][rd_ptr_q[1]] : mem_q[0][rd_ptr_q[0]];

  always_comb begin
    count_d = count_q;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
    if (|pop) begin
      if (pop_val) begin
        if (count_q == MaxCnt) begin
          ovf_d = 1'b1;
`ifdef OCC_SAT_EN
          count_d = count_q;
`else
          count_d = '0;
`endif
        end else begin
          count_d = count_q + CntOne;
        end
      end else begin
        if (count_q == '0) begin
          unf_d = 1'b1;
`ifdef OCC_SAT_EN
          count_d = '0;
`else
          count_d = MaxCnt;
`endif
        end else begin
          count_d = count_q - CntOne;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int l = 0; l < 2; l++) begin
        mem_q[l]    <= '0;
        wr_ptr_q[l] <= '0;
        rd_ptr_q[l] <= '0;
        occ_q[l]    <= '0;
      end
    end else begin
      for (int l = 0; l < 2; l++) begin
        if (push_ok[l]) begin
          mem_q[l][wr_ptr_q[l]] <= push_val[l];
          wr_ptr_q[l]           <= wr_ptr_q[l] + PtrOne;
        end
        if (pop[l]) begin
          rd_ptr_q[l] <= rd_ptr_q[l] + PtrOne;
        end
        if (push_ok[l] && !pop[l]) begin
          occ_q[l] <= occ_q[l] + OccOne;
        end else if (!push_ok[l] && pop[l]) begin
          occ_q[l] <= occ_q[l] - OccOne;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StLast1;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      drop_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      drop_q  <= |lost;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign count = count_q;
  assign full  = (count_q == MaxCnt);
  assign empty = (count_q == '0);
  assign busy  = |not_empty;
  assign drop  = drop_q;
  assign ovf   = ovf_q;
  assign unf   = unf_q;

endmodule
